uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: accepts one byte at a time over a valid/ready handshake and shifts it out LSB-first as an 8N1 frame (optionally 8E1) on a single line. It is the transmit-side counterpart to the board's registered input-capture logic, driving data off-chip rather than sampling it in. It sits between the fabric logic (byte producer) and the FPGA TX pin.

## Interface
- CLKS_PER_BIT, 278, clock cycles per serial bit (32 MHz / 115200 baud); legal range 2..65535
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- tx_data  input  8  byte to transmit, sampled only at handshake
- tx_valid  input  1  producer has a byte on tx_data
- tx_ready  output  1  transmitter can accept a byte this cycle
- tx  output  1  serial line, idle high
- tx_busy  output  1  frame in progress (start bit through stop bit)

## Operation
- Reset values: tx=1, tx_ready=1, tx_busy=0, state IDLE, counters 0.
- Handshake: byte accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_data latched into shift register at that edge; later changes to tx_data have no effect on the frame.
- tx_ready=1 only in IDLE; tx_valid outside IDLE is ignored (no queueing, no error flag).
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1; on handshake go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, bit 0 first, each CLKS_PER_BIT cycles; bit index 0..7, leave after index 7 completes.
  - PARITY (macro only): tx = XOR of the 8 latched bits (even parity), CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx_busy=1 in START, DATA, PARITY, STOP.
- Bit timer counts 0..CLKS_PER_BIT-1; restarts at 0 on every state/bit transition; width $clog2(CLKS_PER_BIT).
- tx is registered (no combinational path from inputs to tx).
- Reset asserted mid-frame: frame aborted immediately, outputs return to reset values asynchronously; no partial resume after release.

## Timing
- Handshake at edge N: tx falls and tx_busy rises at edge N+1.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from edge N+1.
- tx_ready rises at the edge that ends STOP; earliest next handshake is that same cycle, so next start bit begins one cycle later: minimum one idle-high cycle between back-to-back frames.
- Data bit k occupies cycles N+1+(k+1)*CLKS_PER_BIT .. N+(k+2)*CLKS_PER_BIT.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in, even parity bit sent between bit 7 and stop; frame 11 bits.
- Not defined: PARITY state and parity logic absent; 8N1, frame 10 bits.

## Structure
- Shared package uart_pkg: state encoding constants (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP), DATA_BITS=8, default CLKS_PER_BIT; reused by the future receiver.
- One sub-module: uart_baud_timer (bit-period counter with synchronous restart, emits bit_done pulse on last cycle of a bit).

## Test plan
- CLKS_PER_BIT=4, send 0x55 -> tx: 4 cycles 0, then 1,0,1,0,1,0,1,0 (4 cycles each), 4 cycles 1; tx_ready low for 40 cycles.
- Back-to-back 0xA5 then 0x3C with tx_valid held -> two correct frames, exactly one idle-high cycle between stop and second start bit.
- Accept 0x0F, change tx_data to 0xF0 and pulse tx_valid mid-frame -> 0x0F transmitted, no second frame, tx_ready stays 0.
- Assert reset in DATA bit 3 -> tx=1, tx_busy=0, tx_ready=1 immediately; after release, sending 0x81 yields a clean frame.
- UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
- After reset with tx_valid=0 for 100 cycles -> tx constant 1, tx_busy 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and the default bit period.
// Used by the transmitter and intended for the future receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 278;  // 32 MHz / 115200 baud

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and pulses bit_done on
// the last cycle of each bit period, wrapping to 0 so the next bit starts aligned.
module uart_baud_timer #(
    parameter int unsigned CLKS_PER_BIT = 278
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q + CntW'(1);
        bit_done = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d    = '0;
            bit_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, LSB-first 8N1 serial output on a registered line.
// Define UART_TX_PARITY_EN to insert an even parity bit between bit 7 and stop (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   bit_done;
    logic                   handshake;

    assign tx_ready  = (state_q == ST_IDLE);
    assign handshake = tx_valid && tx_ready;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;

    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d   = ST_START;
                    data_d    = tx_data;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line follows the current state one cycle later, keeping tx free of input paths.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != ST_IDLE);
        unique case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(data_q);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; frames are sampled on falling edges.
// Build with UART_TX_PARITY_EN defined to exercise the 8E1 frame.
module tb_uart_tx;

    localparam int unsigned C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels, LSB first: start, data, [parity], stop.
    function automatic logic [FrameBits-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Called after a falling edge; returns just after the handshake rising edge.
    task automatic start_byte(input string tag, input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        check_eq({tag, " ready_pre"}, tx_ready, 1'b1);
        @(posedge clk);
    endtask

    // Called just after the handshake edge; ends on the falling edge where tx_ready is back.
    task automatic check_frame(input string tag, input logic [FrameBits-1:0] frame,
                               input logic hold);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        check_eq({tag, " gap_tx"}, tx, 1'b1);
        check_eq({tag, " gap_busy"}, tx_busy, 1'b0);
        check_eq({tag, " hs_ready"}, tx_ready, 1'b0);
        for (int i = 0; i < int'(FrameBits * C); i++) begin
            @(negedge clk);
            check_eq($sformatf("%s tx bit%0d cyc%0d", tag, i / C, i), tx, frame[i / C]);
            check_eq($sformatf("%s busy cyc%0d", tag, i), tx_busy, 1'b1);
            check_eq($sformatf("%s ready cyc%0d", tag, i), tx_ready,
                     (i == int'(FrameBits * C) - 1) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst tx", tx, 1'b1);
        check_eq("rst ready", tx_ready, 1'b1);
        check_eq("rst busy", tx_busy, 1'b0);
        reset = 1'b1;

        // Quiet line after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_eq("idle tx", tx, 1'b1);
            check_eq("idle busy", tx_busy, 1'b0);
        end

        // 0x55: alternating data, 40 cycles of tx_ready low.
        start_byte("b55", 8'h55);
`ifdef UART_TX_PARITY_EN
        check_frame("b55", 11'b1_0_01010101_0, 1'b0);
`else
        check_frame("b55", 10'b1_01010101_0, 1'b0);
`endif

        // Back-to-back with tx_valid held: the gap check of the second frame is the idle cycle.
        start_byte("bA5", 8'hA5);
        check_frame("bA5", frame_of(8'hA5), 1'b1);
        start_byte("b3C", 8'h3C);
        check_frame("b3C", frame_of(8'h3C), 1'b0);

        // Data change and valid pulse mid-frame must be ignored.
        start_byte("b0F", 8'h0F);
        fork
            check_frame("b0F", frame_of(8'h0F), 1'b0);
            begin
                repeat (12) @(negedge clk);
                tx_data  = 8'hF0;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("post0F tx", tx, 1'b1);
            check_eq("post0F busy", tx_busy, 1'b0);
            check_eq("post0F ready", tx_ready, 1'b1);
        end

        // Reset during data bit 3 (cycles N+17..N+20 at C=4); bit 3 of 0xF0 is 0.
        start_byte("rstF0", 8'hF0);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (18) @(negedge clk);
        check_eq("pre_rst tx", tx, 1'b0);
        check_eq("pre_rst busy", tx_busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst tx", tx, 1'b1);
        check_eq("async_rst busy", tx_busy, 1'b0);
        check_eq("async_rst ready", tx_ready, 1'b1);
        @(negedge clk);
        check_eq("held_rst tx", tx, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst tx", tx, 1'b1);
        start_byte("b81", 8'h81);
        check_frame("b81", frame_of(8'h81), 1'b0);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 has three ones -> 1; 0x03 has two -> 0; 44-cycle frames.
        start_byte("p07", 8'h07);
        check_frame("p07", 11'b1_1_00000111_0, 1'b0);
        start_byte("p03", 8'h03);
        check_frame("p03", 11'b1_0_00000011_0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
